// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the TSC multi-cycle control unit
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_BNE = 4'h0;
  localparam logic [3:0] OP_BEQ = 4'h1;
  localparam logic [3:0] OP_BGZ = 4'h2;
  localparam logic [3:0] OP_BLZ = 4'h3;
  localparam logic [3:0] OP_ADI = 4'h4;
  localparam logic [3:0] OP_ORI = 4'h5;
  localparam logic [3:0] OP_LHI = 4'h6;
  localparam logic [3:0] OP_LWD = 4'h7;
  localparam logic [3:0] OP_SWD = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JAL = 4'hA;
  localparam logic [3:0] ALU_OP = 4'hF;

  // R-type functions 0..FN_SHR are the plain ALU operations
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC1 = 2'd2;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_IMM,
    CLS_BRANCH,
    CLS_LWD,
    CLS_SWD,
    CLS_JMP,
    CLS_JAL,
    CLS_JPR,
    CLS_JRL,
    CLS_HLT
  } instr_class_e;

  function automatic logic uses_imm_operand(input instr_class_e c);
    return (c == CLS_IMM) || (c == CLS_LWD) || (c == CLS_SWD);
  endfunction

  function automatic logic is_link(input instr_class_e c);
    return (c == CLS_JAL) || (c == CLS_JRL);
  endfunction

  function automatic logic is_mem_access(input instr_class_e c);
    return (c == CLS_LWD) || (c == CLS_SWD);
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - maps an instruction word onto its control class
module instr_class_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] instr,
  output instr_class_e         instr_class
);

  logic [3:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[WORD_SIZE-1 -: 4];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[WORD_SIZE-5:6];

  always_comb begin
    instr_class = CLS_NOP;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: instr_class = CLS_BRANCH;
      OP_ADI, OP_ORI, OP_LHI:         instr_class = CLS_IMM;
      OP_LWD:                         instr_class = CLS_LWD;
      OP_SWD:                         instr_class = CLS_SWD;
      OP_JMP:                         instr_class = CLS_JMP;
      OP_JAL:                         instr_class = CLS_JAL;
      ALU_OP: begin
        // unknown function codes fall through as CLS_NOP
        if (funct <= FN_SHR) begin
          instr_class = CLS_ALU;
        end else if (funct == FN_JPR) begin
          instr_class = CLS_JPR;
        end else if (funct == FN_JRL) begin
          instr_class = CLS_JRL;
        end else if (funct == FN_HLT) begin
          instr_class = CLS_HLT;
        end
      end
      default: instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - TSC multi-cycle control FSM with retire counter and halt latch
module multi_cycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic                 b_cond,
  input  logic                 mem_ack,
  output logic                 read_m,
  output logic                 write_m,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           wb_src,
  output logic                 is_halted,
  output logic [CNT_W-1:0]     num_inst,
  output logic [2:0]           state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_inst_q, num_inst_d;
  logic             halted_q, halted_d;
  logic             retire;
  instr_class_e     cls;

  instr_class_decode #(
    .WORD_SIZE(WORD_SIZE)
  ) u_decode (
    .instr      (instr),
    .instr_class(cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IF;
      num_inst_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_inst_q <= num_inst_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    num_inst_d = num_inst_q;
    halted_d   = halted_q;
    retire     = 1'b0;
    read_m     = 1'b0;
    write_m    = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    wb_src     = WB_SRC_ALU;

    case (state_q)
      ST_IF: begin
        read_m = 1'b1;
        if (mem_ack) begin
          ir_write = 1'b1;
          state_d  = ST_ID;
        end
      end

      ST_ID: begin
        case (cls)
          CLS_JMP, CLS_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            retire   = 1'b1;
            state_d  = ST_IF;
          end
          CLS_JPR, CLS_JRL: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
            retire   = 1'b1;
            state_d  = ST_IF;
          end
          CLS_HLT: begin
            retire   = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          CLS_NOP: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_SEQ;
            retire   = 1'b1;
            state_d  = ST_IF;
          end
          default: state_d = ST_EX;
        endcase
        // link register write shares the jump cycle
        if (is_link(cls)) begin
          reg_write = 1'b1;
          wb_src    = WB_SRC_PC1;
        end
      end

      ST_EX: begin
        alu_src = uses_imm_operand(cls);
        if (cls == CLS_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = b_cond ? PC_SRC_BRANCH : PC_SRC_SEQ;
          retire   = 1'b1;
          state_d  = ST_IF;
        end else if (is_mem_access(cls)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        i_or_d  = 1'b1;
        write_m = (cls == CLS_SWD);
        read_m  = (cls != CLS_SWD);
        if (mem_ack) begin
          if (cls == CLS_SWD) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_SEQ;
            retire   = 1'b1;
            state_d  = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        wb_src    = (cls == CLS_LWD) ? WB_SRC_MEM : WB_SRC_ALU;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_SEQ;
        retire    = 1'b1;
        state_d   = ST_IF;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IF;
    endcase

    if (retire) begin
      num_inst_d = num_inst_q + CNT_W'(1);
    end

    // a request pending when reset arrives must drop in the reset cycle itself
    if (reset) begin
      read_m    = 1'b0;
      write_m   = 1'b0;
      i_or_d    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_SEQ;
      alu_src   = 1'b0;
      reg_write = 1'b0;
      wb_src    = WB_SRC_ALU;
    end
  end

  assign state     = state_q;
  assign num_inst  = num_inst_q;
  assign is_halted = halted_q;

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Parametrised multi-cycle control unit for the TSC-style 16-bit CPU. It is a Moore-style FSM that sequences every instruction through fetch, decode, execute, memory and write-back. It drives all datapath strobes and holds each memory request until the memory acknowledges it. It also counts retired instructions and latches a halt state.

## Interface
Parameters:
- WORD_SIZE, 16, width of instruction, PC and counters.
- CNT_W, WORD_SIZE, width of `num_inst`.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- instr  in  WORD_SIZE  instruction register contents. Stable from the cycle after `ir_write`.
- b_cond  in  1  branch-condition result from the datapath ALU, valid in EX.
- mem_ack  in  1  memory read data valid / write accepted. Sampled only while `read_m` or `write_m` is high.
- read_m  out  1  memory read request.
- write_m  out  1  memory write request.
- i_or_d  out  1  address select: 0 = PC (fetch), 1 = ALU result (data).
- ir_write  out  1  load instruction register.
- pc_write  out  1  update PC this cycle.
- pc_src  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target, 3 = register rs.
- alu_src  out  1  ALU operand B: 0 = register, 1 = immediate.
- reg_write  out  1  register-file write enable.
- wb_src  out  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC+1.
- is_halted  out  1  high after HLT retires.
- num_inst  out  CNT_W  count of retired instructions.
- state  out  3  current FSM state, for debug.

## Operation
- States: IF, ID, EX, MEM, WB, HALT.
- IF: `read_m`=1, `i_or_d`=0.
  - Holds until `mem_ack`.
  - On the ack cycle: `ir_write`=1, then go to ID.
- ID: classify `instr` using opcode and function field.
  - JMP: `pc_write`, `pc_src`=2, retire, go to IF.
  - JPR: `pc_write`, `pc_src`=3, retire, go to IF.
  - JAL / JRL: as JMP / JPR, plus `reg_write`=1 and `wb_src`=2 (link to r2), same cycle.
  - HLT: retire, go to HALT.
  - Undefined opcode/function: retire as a NOP (`pc_write`, `pc_src`=0), go to IF.
  - All other instructions: go to EX.
- EX:
  - ADI/ORI/LHI/LWD/SWD: `alu_src`=1.
  - Branches (BNE/BEQ/BGZ/BLZ): `pc_write`=1, `pc_src` = `b_cond` ? 1 : 0, retire, go to IF.
  - ALU/ADI/ORI/LHI: go to WB.
  - LWD/SWD: go to MEM.
- MEM: `i_or_d`=1, with `read_m` (LWD) or `write_m` (SWD) held until `mem_ack`.
  - LWD on ack: go to WB.
  - SWD on ack: `pc_write`, `pc_src`=0, retire, go to IF.
- WB: `reg_write`=1, `wb_src` = 1 for LWD else 0, `pc_write`, `pc_src`=0, retire, go to IF.
- HALT: all strobes 0, `is_halted`=1. Absorbing; only `reset` leaves it.
- Retire: `num_inst` increments by 1 on the retire cycle; wraps modulo 2^CNT_W.
- Outputs are decoded combinationally from the state register and `instr` only. No output depends combinationally on `mem_ack` except `ir_write` and the ack-cycle `pc_write`.

## Timing
- Reset cycle and the cycle after: state = IF, `num_inst`=0, `is_halted`=0.
  - All strobes 0 while `reset` is high.
  - `read_m` rises in the first cycle after reset deasserts.
- Zero-wait memory (ack in the same cycle as the request): IF and MEM each take 1 cycle.
- Cycles per instruction, zero-wait: JMP/JAL/JPR/JRL/NOP = 2; branch = 3; ALU/ADI/ORI/LHI = 4; SWD = 4; LWD = 5.
- Each wait cycle (request high, `mem_ack`=0) adds 1 cycle. The request stays high, with `i_or_d` unchanged.
- `mem_ack` outside IF/MEM is ignored; a stray ack never advances the FSM.
- Reset asserted mid-request: `read_m`/`write_m` are low in the reset cycle; no retire occurs.
- Reset has priority over every transition, including HALT.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode and function-code constants (ALU_OP, ADI…JRL, HLT);
  - state encoding;
  - `pc_src` and `wb_src` encodings;
  - an instruction-class enum.
- Sub-module `instr_class_decode`: combinational `instr` → instruction class. One instance.
- The FSM, counter and halt flag live in the top module.

## Test plan
- ADI (opcode 4'h4) with zero-wait memory → states IF, ID, EX, WB. `reg_write`=1 only in WB; `num_inst` goes 0→1 at cycle 4.
- LWD (4'h7) with `mem_ack` held low for 3 cycles in MEM → `read_m`=1 and `i_or_d`=1 for 4 cycles; `wb_src`=1 in WB; total 8 cycles.
- BEQ (4'h1) with `b_cond`=1, then again with `b_cond`=0 → retires in EX with `pc_src`=1, then 0; each takes 3 cycles.
- JAL (4'hA) → retires in ID with `pc_src`=2, `reg_write`=1 and `wb_src`=2 in the same cycle.
- HLT → `is_halted`=1; FSM stays in HALT for 20 cycles despite `mem_ack` pulses. Reset then returns to IF with `num_inst`=0.
- Reset asserted during a pending SWD (4'h8) `write_m` → `write_m` is 0 in the reset cycle, `num_inst` is unchanged, and the fetch restarts afterwards.
